mmio_port_unit: RTL and testbench

Memory-mapped I/O peripheral on the MEM-stage data bus, alongside DataMemory, downstream of the EX stage's ALU result.
- Decodes load/store addresses in a 64-byte window.
- Owns the registered 32-bit PortOut.
- Synchronises the 8-bit PortIn and detects changes on it, with sticky status and a saturating event counter readable by software.

---
 rtl/mmio_port_unit.sv | 178 +++++++++++++++++
 tb/tb_mmio_port_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_unit.sv
// Memory-mapped I/O port unit: 64-byte register window, registered PortOut,
// synchronised PortIn with change events. Define MMIO_IRQ_EN to add CTRL.IE and the IRQ output.
module mmio_port_unit #(
  parameter logic [31:0] IO_BASE      = 32'hFFFF_0000,
  parameter int          PORTIN_WIDTH = 8,
  parameter int          CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             Address,
  input  logic [31:0]             WriteData,
  input  logic                    MemWrite,
  input  logic                    MemRead,
  input  logic [PORTIN_WIDTH-1:0] PortIn,
`ifdef MMIO_IRQ_EN
  output logic                    IRQ,
`endif
  output logic                    Hit,
  output logic [31:0]             ReadData,
  output logic [31:0]             PortOut
);

  localparam logic [3:0] OFF_OUT    = 4'd0;
  localparam logic [3:0] OFF_IN     = 4'd1;
  localparam logic [3:0] OFF_STATUS = 4'd2;
  localparam logic [3:0] OFF_SET    = 4'd3;
  localparam logic [3:0] OFF_CLR    = 4'd4;
  localparam logic [3:0] OFF_CTRL   = 4'd5;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {PRIME0, PRIME1, RUN} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             out_q, out_d;
  logic [PORTIN_WIDTH-1:0] sync1_q, sync2_q, prev_q, prev_d;
  logic                    pend_q, pend_d;
  logic                    ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic        wr_en;
  logic [3:0]  word_off;
  logic        change;
  logic        clr_pend;
  logic        clr_ovf;
  logic [31:0] status_word;
  logic [31:0] in_word;
  logic        unused_addr_bits;

`ifdef MMIO_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;
`endif

  assign Hit              = (Address[31:6] == IO_BASE[31:6]);
  assign word_off         = Address[5:2];
  assign wr_en            = Hit & MemWrite;
  assign unused_addr_bits = ^Address[1:0];
  assign change           = (sync2_q != prev_q) && (state_q == RUN);
  assign clr_pend         = wr_en && (word_off == OFF_STATUS) && WriteData[0];
  assign clr_ovf          = wr_en && (word_off == OFF_STATUS) && WriteData[1];
  assign PortOut          = out_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIME0:  state_d = PRIME1;
      PRIME1:  state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = PRIME0;
    endcase
  end

  // While priming, prev follows the value sync2 is about to take, so whatever
  // PortIn held at reset release is the baseline rather than an event.
  assign prev_d = (state_q == RUN) ? sync2_q : sync1_q;

  always_comb begin
    out_d = out_q;
    if (wr_en) begin
      case (word_off)
        OFF_OUT: out_d = WriteData;
        OFF_SET: out_d = out_q | WriteData;
        OFF_CLR: out_d = out_q & ~WriteData;
        default: out_d = out_q;
      endcase
    end
  end

  // A change in the same cycle as a W1C wins: the new event is counted from zero.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (clr_pend) begin
      pend_d = 1'b0;
      cnt_d  = '0;
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (change) begin
      pend_d = 1'b1;
      if (pend_q) begin
        ovf_d = 1'b1;
      end
      if (clr_pend) begin
        cnt_d = CNT_ONE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

`ifdef MMIO_IRQ_EN
  always_comb begin
    ie_d = ie_q;
    if (wr_en && (word_off == OFF_CTRL)) begin
      ie_d = WriteData[0];
    end
    irq_d = ie_q & (pend_q | pend_d);
  end
  assign IRQ = irq_q;
`endif

  always_comb begin
    status_word                   = '0;
    status_word[0]                = pend_q;
    status_word[1]                = ovf_q;
    status_word[8 +: CNT_WIDTH]   = cnt_q;
    in_word                       = '0;
    in_word[PORTIN_WIDTH-1:0]     = sync2_q;
    ReadData                      = '0;
    if (Hit && MemRead) begin
      case (word_off)
        OFF_OUT:    ReadData = out_q;
        OFF_IN:     ReadData = in_word;
        OFF_STATUS: ReadData = status_word;
`ifdef MMIO_IRQ_EN
        OFF_CTRL:   ReadData = {31'd0, ie_q};
`endif
        default:    ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= PRIME0;
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MMIO_IRQ_EN
      ie_q    <= 1'b0;
      irq_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sync1_q <= PortIn;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
`ifdef MMIO_IRQ_EN
      ie_q    <= ie_d;
      irq_q   <= irq_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_port_unit.sv
// Directed self-checking bench for mmio_port_unit; IRQ steps compile only with MMIO_IRQ_EN.
module tb_mmio_port_unit;

  localparam logic [31:0] A_OUT    = 32'hFFFF_0000;
  localparam logic [31:0] A_IN     = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_SET    = 32'hFFFF_000C;
  localparam logic [31:0] A_CLR    = 32'hFFFF_0010;
  localparam logic [31:0] A_CTRL   = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic        Hit;
  logic [31:0] ReadData;
  logic [31:0] PortOut;
`ifdef MMIO_IRQ_EN
  logic        IRQ;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_port_unit dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .PortIn    (PortIn),
`ifdef MMIO_IRQ_EN
    .IRQ       (IRQ),
`endif
    .Hit       (Hit),
    .ReadData  (ReadData),
    .PortOut   (PortOut)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Address = addr;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] data);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
    PortIn = 8'hA5;

    // 1: reset with nonzero PortIn, then release: no event, IN follows after two edges
    tick(); tick();
    chk("rst_portout", PortOut, 32'h0);
    rd("rst_status", A_STATUS, 32'h0);
    rd("rst_in", A_IN, 32'h0);
    reset = 1'b1;
    tick();
    rd("in_1st_cycle", A_IN, 32'h0);
    tick();
    rd("in_2nd_cycle", A_IN, 32'h0000_00A5);
    for (int i = 0; i < 10; i++) begin
      tick();
      rd("prime_status", A_STATUS, 32'h0);
    end
    chk("prime_portout", PortOut, 32'h0);
    Address = A_OUT; #1;
    chk("hit_base", {31'd0, Hit}, 32'h1);

    // 2: OUT, OUT_SET, OUT_CLR
    st(A_OUT, 32'h1234_5678);
    chk("out_write", PortOut, 32'h1234_5678);
    st(A_SET, 32'h0000_00F0);
    chk("out_set", PortOut, 32'h1234_56F8);
    st(A_CLR, 32'h0000_0018);
    chk("out_clr", PortOut, 32'h1234_56E0);
    rd("rd_set", A_SET, 32'h0);
    rd("rd_clr", A_CLR, 32'h0);
    rd("rd_out_lowbits", 32'hFFFF_0003, 32'h1234_56E0);

    // 3: events, overflow, W1C
    PortIn = 8'h00;
    tick(); tick(); tick(); tick();
    rd("status_a5_to_00", A_STATUS, 32'h0000_0101);
    st(A_STATUS, 32'h3);
    rd("status_cleared", A_STATUS, 32'h0);
    PortIn = 8'h01;
    tick();
    rd("in_before_sync", A_IN, 32'h0);
    tick();
    rd("in_after_sync", A_IN, 32'h1);
    rd("pend_not_yet", A_STATUS, 32'h0);
    tick();
    rd("pend_set", A_STATUS, 32'h0000_0101);
    tick();
    PortIn = 8'h03;
    tick(); tick(); tick(); tick();
    rd("status_ovf", A_STATUS, 32'h0000_0203);
    st(A_STATUS, 32'h1);
    rd("w1c_pend", A_STATUS, 32'h0000_0002);
    st(A_STATUS, 32'h2);
    rd("w1c_ovf", A_STATUS, 32'h0);

    // 4: saturation, then change coinciding with W1C of bit0
    for (int i = 0; i < 300; i++) begin
      PortIn = PortIn ^ 8'h01;
      tick(); tick();
    end
    tick(); tick();
    rd("cnt_sat", A_STATUS, 32'h0000_FF03);
    PortIn = PortIn ^ 8'h01;
    tick(); tick();
    st(A_STATUS, 32'h1);
    rd("change_vs_w1c", A_STATUS, 32'h0000_0103);
    tick(); tick();
    rd("change_vs_w1c_hold", A_STATUS, 32'h0000_0103);

    // 5: misses, reserved offsets, CTRL in this build, reset during a store
    Address = 32'h1001_0000; #1;
    chk("miss_hit", {31'd0, Hit}, 32'h0);
    st(32'h1001_0000, 32'hFFFF_FFFF);
    chk("miss_store", PortOut, 32'h1234_56E0);
    st(32'hFFFF_0018, 32'hFFFF_FFFF);
    chk("reserved_store", PortOut, 32'h1234_56E0);
    rd("reserved_read", 32'hFFFF_0020, 32'h0);
    chk("reserved_hit", {31'd0, Hit}, 32'h1);
    rd("miss_read", 32'h1001_0000, 32'h0);
    Address = A_OUT; MemRead = 1'b0; #1;
    chk("no_memread", ReadData, 32'h0);
`ifndef MMIO_IRQ_EN
    st(A_CTRL, 32'h1);
    rd("ctrl_absent", A_CTRL, 32'h0);
`endif
    reset = 1'b0;
    st(A_OUT, 32'hDEAD_BEEF);
    chk("reset_store", PortOut, 32'h0);
    rd("reset_status", A_STATUS, 32'h0);
    rd("reset_in", A_IN, 32'h0);
    reset = 1'b1;
    tick(); tick(); tick(); tick();
    rd("rerelease_status", A_STATUS, 32'h0);
    rd("rerelease_in", A_IN, 32'h2);

`ifdef MMIO_IRQ_EN
    // 6: interrupt enable, assertion and release
    st(A_CTRL, 32'h1);
    rd("ctrl_ie", A_CTRL, 32'h1);
    PortIn = PortIn ^ 8'h01;
    tick(); tick();
    chk("irq_before", {31'd0, IRQ}, 32'h0);
    tick();
    rd("irq_pend", A_STATUS, 32'h0000_0101);
    chk("irq_rise", {31'd0, IRQ}, 32'h1);
    st(A_STATUS, 32'h1);
    chk("irq_hold", {31'd0, IRQ}, 32'h1);
    tick();
    chk("irq_drop", {31'd0, IRQ}, 32'h0);
    st(A_CTRL, 32'h0);
    PortIn = PortIn ^ 8'h01;
    tick(); tick(); tick(); tick();
    rd("irq_off_pend", A_STATUS, 32'h0000_0101);
    chk("irq_disabled", {31'd0, IRQ}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
